// File: rtl/if_id_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : if_id_stall_ctrl
// Purpose  : IF/ID pipeline register with stall / branch-wait / flush control.
//            Holds the fetched instruction while hazard detection requests a
//            stall. It waits for a control-flow instruction to resolve in EX,
//            flushes the wrong-path fetch on a taken redirect, and keeps
//            saturating stall and flush statistics.
// Ports    : clk, rst                 - clock, async active-high reset
//            if_pc, if_instruction,
//            if_valid                 - fetch stage outputs
//            holdpc                   - stall request from hazard detection
//            ex_branch_resolved/taken - control-flow resolution from EX
//            if_id_pc/instruction/
//            valid                    - registered IF/ID contents
//            pc_write_en              - fetch PC update enable (combinational)
//            id_ex_bubble             - force NOP into ID/EX (combinational)
//            state                    - FSM state (RUN=0, WAIT_BR=1, FLUSH=2)
//            stall_count, flush_count - saturating statistics counters
//            br_timeout_err           - sticky branch-wait timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module if_id_stall_ctrl #(
   parameter logic [31:0] NOP_INSTR  = 32'h00000013,
   parameter int          BR_TIMEOUT = 8,
   parameter int          CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      if_pc,
   input  logic [31:0]      if_instruction,
   input  logic             if_valid,
   input  logic             holdpc,
   input  logic             ex_branch_resolved,
   input  logic             ex_branch_taken,
   output logic [31:0]      if_id_pc,
   output logic [31:0]      if_id_instruction,
   output logic             if_id_valid,
   output logic             pc_write_en,
   output logic             id_ex_bubble,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count,
   output logic             br_timeout_err
);

   // Timer holds 0 .. BR_TIMEOUT-1 while waiting; one spare bit keeps the
   // width legal for BR_TIMEOUT = 1.
   localparam int                TMR_W      = $clog2(BR_TIMEOUT + 1);
   localparam logic [TMR_W-1:0]  c_tmr_last = TMR_W'(BR_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  c_cnt_max  = '1;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      WAIT_BR = 2'd1,
      FLUSH   = 2'd2
   } state_t;

   state_t           r_state;
   logic [31:0]      r_pc;
   logic [31:0]      r_instr;
   logic             r_valid;
   logic [TMR_W-1:0] r_timer;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic             r_br_err;

   logic             w_is_cf;
   logic             w_run_go;
   logic             w_pc_write_en;
   logic             w_id_ex_bubble;

   // Branch, jalr and jal all redirect fetch; decided on opcode[6:2] only.
   assign w_is_cf = (r_instr[6:2] == 5'b11000) ||
                    (r_instr[6:2] == 5'b11001) ||
                    (r_instr[6:2] == 5'b11011);

   // Normal advancing cycle: RUN with no stall request.
   assign w_run_go = (r_state == RUN) && !holdpc;

   // FLUSH lets the redirected PC advance while still bubbling ID/EX.
   // Reset forces the safe combination (PC frozen, bubble) immediately.
   assign w_pc_write_en  = !rst && (w_run_go || (r_state == FLUSH));
   assign w_id_ex_bubble = rst || !w_run_go;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= RUN;
         r_pc        <= 32'd0;
         r_instr     <= NOP_INSTR;
         r_valid     <= 1'b0;
         r_timer     <= '0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
         r_br_err    <= 1'b0;
      end else begin
         if (!w_pc_write_en && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end

         case (r_state)
            RUN: begin
               if (!holdpc) begin
                  if (if_valid) begin
                     r_pc    <= if_pc;
                     r_instr <= if_instruction;
                     r_valid <= 1'b1;
                  end else begin
                     r_instr <= NOP_INSTR;
                     r_valid <= 1'b0;
                  end
                  // The instruction leaving ID is control flow: freeze
                  // fetch until EX tells us where to go.
                  if (r_valid && w_is_cf) begin
                     r_state <= WAIT_BR;
                     r_timer <= '0;
                  end
               end
            end

            WAIT_BR: begin
               r_timer <= r_timer + 1'b1;
               // Resolution beats the timeout when both land together.
               if (ex_branch_resolved) begin
                  if (ex_branch_taken) begin
                     r_state <= FLUSH;
                     if (r_flush_cnt != c_cnt_max) begin
                        r_flush_cnt <= r_flush_cnt + 1'b1;
                     end
                  end else begin
                     r_state <= RUN;
                  end
               end else if (r_timer == c_tmr_last) begin
                  r_state  <= RUN;
                  r_br_err <= 1'b1;
               end
            end

            FLUSH: begin
               // Fall-through instruction is on the wrong path: squash it.
               r_instr <= NOP_INSTR;
               r_valid <= 1'b0;
               r_state <= RUN;
            end

            default: begin
               r_state <= RUN;
            end
         endcase
      end
   end

   assign if_id_pc          = r_pc;
   assign if_id_instruction = r_instr;
   assign if_id_valid       = r_valid;
   assign pc_write_en       = w_pc_write_en;
   assign id_ex_bubble      = w_id_ex_bubble;
   assign state             = r_state;
   assign stall_count       = r_stall_cnt;
   assign flush_count       = r_flush_cnt;
   assign br_timeout_err    = r_br_err;

endmodule
`default_nettype wire

// File: tb/tb_if_id_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_stall_ctrl
// Purpose  : Self-checking bench for if_id_stall_ctrl. Vector table plus
//            hand-written timeout, precedence and async-reset sequences.
//            A second instance with 3-bit counters covers saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_stall_ctrl;

   localparam logic [31:0] c_nop  = 32'h00000013;
   localparam logic [31:0] c_addi = 32'h00100093;
   localparam logic [31:0] c_beq  = 32'h00000063;
   localparam logic [31:0] c_jal  = 32'h0000006F;
   localparam logic [31:0] c_jalr = 32'h00000067;
   localparam logic [1:0]  S_RUN  = 2'd0;
   localparam logic [1:0]  S_WAIT = 2'd1;
   localparam logic [1:0]  S_FL   = 2'd2;

   logic        clk;
   logic        rst;
   logic [31:0] if_pc;
   logic [31:0] if_instruction;
   logic        if_valid;
   logic        holdpc;
   logic        ex_branch_resolved;
   logic        ex_branch_taken;

   logic [31:0] if_id_pc;
   logic [31:0] if_id_instruction;
   logic        if_id_valid;
   logic        pc_write_en;
   logic        id_ex_bubble;
   logic [1:0]  state;
   logic [15:0] stall_count;
   logic [15:0] flush_count;
   logic        br_timeout_err;

   logic [31:0] s_pc;
   logic [31:0] s_instr;
   logic        s_valid;
   logic        s_pcwe;
   logic        s_bub;
   logic [1:0]  s_state;
   logic [2:0]  s_stall;
   logic [2:0]  s_flush;
   logic        s_err;

   if_id_stall_ctrl dut (
      .clk(clk), .rst(rst), .if_pc(if_pc), .if_instruction(if_instruction),
      .if_valid(if_valid), .holdpc(holdpc),
      .ex_branch_resolved(ex_branch_resolved), .ex_branch_taken(ex_branch_taken),
      .if_id_pc(if_id_pc), .if_id_instruction(if_id_instruction),
      .if_id_valid(if_id_valid), .pc_write_en(pc_write_en),
      .id_ex_bubble(id_ex_bubble), .state(state), .stall_count(stall_count),
      .flush_count(flush_count), .br_timeout_err(br_timeout_err)
   );

   if_id_stall_ctrl #(.CNT_W(3)) dut_sat (
      .clk(clk), .rst(rst), .if_pc(if_pc), .if_instruction(if_instruction),
      .if_valid(if_valid), .holdpc(holdpc),
      .ex_branch_resolved(ex_branch_resolved), .ex_branch_taken(ex_branch_taken),
      .if_id_pc(s_pc), .if_id_instruction(s_instr),
      .if_id_valid(s_valid), .pc_write_en(s_pcwe),
      .id_ex_bubble(s_bub), .state(s_state), .stall_count(s_stall),
      .flush_count(s_flush), .br_timeout_err(s_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ctl = {rst, holdpc, if_valid, ex_branch_resolved, ex_branch_taken}
   // comb = {pc_write_en, id_ex_bubble} expected before the edge
   // remaining fields: registered outputs expected after the edge
   typedef struct {
      logic [4:0]  ctl;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [1:0]  comb;
      logic [1:0]  st;
      logic [31:0] opc;
      logic [31:0] oinstr;
      logic        ovld;
      logic [15:0] stall;
      logic [15:0] flush;
      logic        err;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic vec_t mk(input logic [4:0] ctl, input logic [31:0] pc,
                               input logic [31:0] instr, input logic [1:0] comb,
                               input logic [1:0] st, input logic [31:0] opc,
                               input logic [31:0] oinstr, input logic ovld,
                               input logic [15:0] stall, input logic [15:0] flush,
                               input logic err);
      vec_t v;
      v.ctl = ctl; v.pc = pc; v.instr = instr; v.comb = comb; v.st = st;
      v.opc = opc; v.oinstr = oinstr; v.ovld = ovld; v.stall = stall;
      v.flush = flush; v.err = err;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      vec_t       e;
      logic [2:0] sat_exp;
      @(negedge clk);
      {rst, holdpc, if_valid, ex_branch_resolved, ex_branch_taken} = v.ctl;
      if_pc          = v.pc;
      if_instruction = v.instr;
      sb.push_back(v);
      #1;
      chk($sformatf("v%0d pc_write_en", idx), 32'(pc_write_en), 32'(v.comb[1]));
      chk($sformatf("v%0d id_ex_bubble", idx), 32'(id_ex_bubble), 32'(v.comb[0]));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      sat_exp = (e.stall > 16'd7) ? 3'd7 : e.stall[2:0];
      chk($sformatf("v%0d state", idx), 32'(state), 32'(e.st));
      chk($sformatf("v%0d if_id_pc", idx), if_id_pc, e.opc);
      chk($sformatf("v%0d if_id_instruction", idx), if_id_instruction, e.oinstr);
      chk($sformatf("v%0d if_id_valid", idx), 32'(if_id_valid), 32'(e.ovld));
      chk($sformatf("v%0d stall_count", idx), 32'(stall_count), 32'(e.stall));
      chk($sformatf("v%0d flush_count", idx), 32'(flush_count), 32'(e.flush));
      chk($sformatf("v%0d br_timeout_err", idx), 32'(br_timeout_err), 32'(e.err));
      chk($sformatf("v%0d sat stall_count", idx), 32'(s_stall), 32'(sat_exp));
   endtask

   task automatic cyc(input logic h, input logic vl, input logic [31:0] p,
                      input logic [31:0] i, input logic r, input logic t);
      @(negedge clk);
      rst = 1'b0; holdpc = h; if_valid = vl; if_pc = p; if_instruction = i;
      ex_branch_resolved = r; ex_branch_taken = t;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; holdpc = 1'b0; if_valid = 1'b0;
      ex_branch_resolved = 1'b0; ex_branch_taken = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; holdpc = 1'b0; if_valid = 1'b0; if_pc = 32'd0;
      if_instruction = c_addi; ex_branch_resolved = 1'b0; ex_branch_taken = 1'b0;

      // Reset, plain flow, two-cycle hold, invalid fetch
      vecs.push_back(mk(5'b10000, 32'h00, c_addi, 2'b01, S_RUN,  32'h00, c_nop,  1'b0, 16'd0, 16'd0, 1'b0));
      vecs.push_back(mk(5'b00100, 32'h00, c_addi, 2'b10, S_RUN,  32'h00, c_addi, 1'b1, 16'd0, 16'd0, 1'b0));
      vecs.push_back(mk(5'b00100, 32'h04, c_addi, 2'b10, S_RUN,  32'h04, c_addi, 1'b1, 16'd0, 16'd0, 1'b0));
      vecs.push_back(mk(5'b00100, 32'h08, c_addi, 2'b10, S_RUN,  32'h08, c_addi, 1'b1, 16'd0, 16'd0, 1'b0));
      vecs.push_back(mk(5'b00100, 32'h10, c_addi, 2'b10, S_RUN,  32'h10, c_addi, 1'b1, 16'd0, 16'd0, 1'b0));
      vecs.push_back(mk(5'b01100, 32'h14, c_addi, 2'b01, S_RUN,  32'h10, c_addi, 1'b1, 16'd1, 16'd0, 1'b0));
      vecs.push_back(mk(5'b01100, 32'h14, c_addi, 2'b01, S_RUN,  32'h10, c_addi, 1'b1, 16'd2, 16'd0, 1'b0));
      vecs.push_back(mk(5'b00000, 32'h14, c_addi, 2'b10, S_RUN,  32'h10, c_nop,  1'b0, 16'd2, 16'd0, 1'b0));
      // Taken beq: three WAIT_BR cycles (holdpc ignored), FLUSH, squash
      vecs.push_back(mk(5'b10000, 32'h00, c_addi, 2'b01, S_RUN,  32'h00, c_nop,  1'b0, 16'd0, 16'd0, 1'b0));
      vecs.push_back(mk(5'b00100, 32'h20, c_beq,  2'b10, S_RUN,  32'h20, c_beq,  1'b1, 16'd0, 16'd0, 1'b0));
      vecs.push_back(mk(5'b00100, 32'h24, c_addi, 2'b10, S_WAIT, 32'h24, c_addi, 1'b1, 16'd0, 16'd0, 1'b0));
      vecs.push_back(mk(5'b00100, 32'h28, c_addi, 2'b01, S_WAIT, 32'h24, c_addi, 1'b1, 16'd1, 16'd0, 1'b0));
      vecs.push_back(mk(5'b01100, 32'h28, c_addi, 2'b01, S_WAIT, 32'h24, c_addi, 1'b1, 16'd2, 16'd0, 1'b0));
      vecs.push_back(mk(5'b00111, 32'h28, c_addi, 2'b01, S_FL,   32'h24, c_addi, 1'b1, 16'd3, 16'd1, 1'b0));
      vecs.push_back(mk(5'b00111, 32'h40, c_addi, 2'b11, S_RUN,  32'h24, c_nop,  1'b0, 16'd3, 16'd1, 1'b0));
      vecs.push_back(mk(5'b00100, 32'h40, c_addi, 2'b10, S_RUN,  32'h40, c_addi, 1'b1, 16'd3, 16'd1, 1'b0));
      // Not-taken beq, resolution ignored in RUN, not-taken jalr
      vecs.push_back(mk(5'b00100, 32'h44, c_beq,  2'b10, S_RUN,  32'h44, c_beq,  1'b1, 16'd3, 16'd1, 1'b0));
      vecs.push_back(mk(5'b00100, 32'h48, c_addi, 2'b10, S_WAIT, 32'h48, c_addi, 1'b1, 16'd3, 16'd1, 1'b0));
      vecs.push_back(mk(5'b00110, 32'h4C, c_addi, 2'b01, S_RUN,  32'h48, c_addi, 1'b1, 16'd4, 16'd1, 1'b0));
      vecs.push_back(mk(5'b00111, 32'h4C, c_addi, 2'b10, S_RUN,  32'h4C, c_addi, 1'b1, 16'd4, 16'd1, 1'b0));
      vecs.push_back(mk(5'b00100, 32'h50, c_jalr, 2'b10, S_RUN,  32'h50, c_jalr, 1'b1, 16'd4, 16'd1, 1'b0));
      vecs.push_back(mk(5'b00100, 32'h54, c_addi, 2'b10, S_WAIT, 32'h54, c_addi, 1'b1, 16'd4, 16'd1, 1'b0));
      vecs.push_back(mk(5'b00110, 32'h58, c_addi, 2'b01, S_RUN,  32'h54, c_addi, 1'b1, 16'd5, 16'd1, 1'b0));

      foreach (vecs[k]) run_vec(k, vecs[k]);

      // Timeout: jal never resolves
      do_reset();
      cyc(1'b0, 1'b1, 32'h60, c_jal,  1'b0, 1'b0);
      cyc(1'b0, 1'b1, 32'h64, c_addi, 1'b0, 1'b0);
      chk("to enter state", 32'(state), 32'(S_WAIT));
      for (int k = 0; k < 7; k++) begin
         cyc(1'b0, 1'b1, 32'h68, c_addi, 1'b0, 1'b0);
         chk($sformatf("to wait%0d state", k + 1), 32'(state), 32'(S_WAIT));
      end
      chk("to pre-limit err", 32'(br_timeout_err), 32'd0);
      cyc(1'b0, 1'b1, 32'h68, c_addi, 1'b0, 1'b0);
      chk("to state", 32'(state), 32'(S_RUN));
      chk("to err", 32'(br_timeout_err), 32'd1);
      chk("to stall_count", 32'(stall_count), 32'd8);
      chk("to sat stall_count", 32'(s_stall), 32'd7);
      chk("to if_id_pc", if_id_pc, 32'h64);
      cyc(1'b0, 1'b1, 32'h68, c_addi, 1'b0, 1'b0);
      chk("to err sticky", 32'(br_timeout_err), 32'd1);
      chk("to resume pc", if_id_pc, 32'h68);

      // Precedence: taken resolution on the 8th WAIT_BR cycle
      do_reset();
      cyc(1'b0, 1'b1, 32'h70, c_jal,  1'b0, 1'b0);
      cyc(1'b0, 1'b1, 32'h74, c_addi, 1'b0, 1'b0);
      for (int k = 0; k < 7; k++) cyc(1'b0, 1'b1, 32'h78, c_addi, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 32'h78, c_addi, 1'b1, 1'b1);
      chk("pr state", 32'(state), 32'(S_FL));
      chk("pr err", 32'(br_timeout_err), 32'd0);
      chk("pr flush_count", 32'(flush_count), 32'd1);
      chk("pr sat stall_count", 32'(s_stall), 32'd7);
      cyc(1'b0, 1'b1, 32'h80, c_addi, 1'b0, 1'b0);
      chk("pr exit state", 32'(state), 32'(S_RUN));
      chk("pr exit valid", 32'(if_id_valid), 32'd0);
      chk("pr exit err", 32'(br_timeout_err), 32'd0);
      chk("pr sat stays max", 32'(s_stall), 32'd7);

      // Async reset in the middle of WAIT_BR
      do_reset();
      cyc(1'b0, 1'b1, 32'h90, c_beq,  1'b0, 1'b0);
      cyc(1'b0, 1'b1, 32'h94, c_addi, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 32'h98, c_addi, 1'b0, 1'b0);
      chk("ar pre state", 32'(state), 32'(S_WAIT));
      chk("ar pre stall", 32'(stall_count), 32'd1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("ar state", 32'(state), 32'(S_RUN));
      chk("ar if_id_pc", if_id_pc, 32'd0);
      chk("ar if_id_instruction", if_id_instruction, c_nop);
      chk("ar if_id_valid", 32'(if_id_valid), 32'd0);
      chk("ar pc_write_en", 32'(pc_write_en), 32'd0);
      chk("ar id_ex_bubble", 32'(id_ex_bubble), 32'd1);
      chk("ar stall_count", 32'(stall_count), 32'd0);
      chk("ar flush_count", 32'(flush_count), 32'd0);
      chk("ar err", 32'(br_timeout_err), 32'd0);
      @(posedge clk);
      #1;
      cyc(1'b0, 1'b1, 32'hA0, c_addi, 1'b0, 1'b0);
      chk("ar post state", 32'(state), 32'(S_RUN));
      chk("ar post pc", if_id_pc, 32'hA0);
      chk("ar post instr", if_id_instruction, c_addi);
      chk("ar post valid", 32'(if_id_valid), 32'd1);
      cyc(1'b0, 1'b1, 32'hA4, c_addi, 1'b0, 1'b0);
      chk("ar next pc", if_id_pc, 32'hA4);
      chk("ar next state", 32'(state), 32'(S_RUN));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
